// File: rtl/w16_twiddle_seq.sv
// Twiddle sequencer for the radix-16 FFT: walks the 64-entry twiddle table
// and streams one complex factor per valid/ready handshake. In inverse mode
// the imaginary part is conjugated.
module w16_twiddle_seq #(
   parameter int unsigned N_ENTRIES = 64,
   parameter int unsigned IDX_W     = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [31:0]       w16r [N_ENTRIES],
   input  logic [31:0]       w16i [N_ENTRIES],
   input  logic              start,
   input  logic              inverse,
   input  logic              flush,
   input  logic              tw_ready,
   output logic              tw_valid,
   output logic [31:0]       tw_r,
   output logic [31:0]       tw_i,
   output logic [IDX_W-1:0]  tw_idx,
   output logic              busy,
   output logic              done
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ENTRIES - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               inv_q, inv_d;
   logic               valid_q, valid_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [31:0]        r_q, r_d;
   logic [31:0]        i_q, i_d;

   logic               load;
   logic [IDX_W-1:0]   ld_idx;
   logic               ld_inv;
   logic [31:0]        ld_im;

   // Next-state, index advance and output-register load.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      inv_d   = inv_q;
      valid_d = valid_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      r_d     = r_q;
      i_d     = i_q;
      load    = 1'b0;
      ld_idx  = idx_q;
      ld_inv  = inv_q;
      ld_im   = '0;

      case (state_q)
         S_IDLE: begin
            // flush in IDLE suppresses a simultaneous start
            if (start && !flush) begin
               state_d = S_RUN;
               inv_d   = inverse;
               ld_inv  = inverse;
               load    = 1'b1;
               ld_idx  = '0;
               valid_d = 1'b1;
               busy_d  = 1'b1;
            end
         end
         S_RUN: begin
            if (flush) begin
               state_d = S_IDLE;
               valid_d = 1'b0;
               busy_d  = 1'b0;
               idx_d   = '0;
            end else if (valid_q && tw_ready) begin
               if (idx_q == LAST_IDX) begin
                  state_d = S_DONE;
                  valid_d = 1'b0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  load   = 1'b1;
                  ld_idx = idx_q + IDX_W'(1);
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            if (flush) begin
               idx_d = '0;
            end
         end
         default: begin
            state_d = S_IDLE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
         end
      endcase

      // Sample the table entry; conjugation never produces a negative zero.
      if (load) begin
         idx_d = ld_idx;
         r_d   = w16r[ld_idx];
         ld_im = w16i[ld_idx];
         if (!ld_inv) begin
            i_d = ld_im;
         end else if (ld_im[30:0] == 31'd0) begin
            i_d = 32'h0000_0000;
         end else begin
            i_d = {~ld_im[31], ld_im[30:0]};
         end
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         inv_q   <= 1'b0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         r_q     <= '0;
         i_q     <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         inv_q   <= inv_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         r_q     <= r_d;
         i_q     <= i_d;
      end
   end

   assign tw_valid = valid_q;
   assign tw_r     = r_q;
   assign tw_i     = i_q;
   assign tw_idx   = idx_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule
